// File: rtl/front_icon_dispatcher.sv
// rtl/front_icon_dispatcher.sv - icon instruction FIFO with round-robin per-channel dispatch slots
// Optional ICON_DISP_BYPASS_EN: an empty FIFO lets a push load a free slot directly.

package pkg_dtypes;
  typedef struct packed {
    logic [7:0]  opcode;
    logic [15:0] src_addr;
    logic [7:0]  rcv_mask;
  } type_icon_instr;
endpackage

module front_icon_dispatcher
  import pkg_dtypes::*;
#(
  parameter int NUM_ICON_CHANNELS = 4,
  parameter int FIFO_DEPTH        = 8
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  type_icon_instr                         icon_instr_i,
  input  logic                                   icon_instr_valid_i,
  output logic                                   icon_instr_ready_o,
  input  logic                                   flush_i,
  output type_icon_instr [NUM_ICON_CHANNELS-1:0] icon_instr_dispatch_o,
  output logic [NUM_ICON_CHANNELS-1:0]           icon_instr_dispatch_valid_o,
  input  logic [NUM_ICON_CHANNELS-1:0]           icon_instr_dispatch_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]            occupancy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (NUM_ICON_CHANNELS > 1) ? $clog2(NUM_ICON_CHANNELS) : 1;

  type_icon_instr          mem [FIFO_DEPTH];
  logic [AW:0]             wr_ptr;
  logic [AW:0]             rd_ptr;
  logic [AW:0]             count;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    push;
  logic                    fifo_wr;
  logic                    pop;
  logic                    bypass;
  logic                    alloc;
  type_icon_instr          alloc_data;

  logic [CW-1:0]                rr;
  logic [CW-1:0]                rr_next;
  logic [CW-1:0]                chosen;
  logic                         any_avail;
  logic [NUM_ICON_CHANNELS-1:0] avail;

  // Extra pointer MSB makes count reach FIFO_DEPTH exactly when full.
  assign count              = wr_ptr - rd_ptr;
  assign fifo_full          = count[AW];
  assign fifo_empty         = (count == '0);
  assign occupancy_o        = count;
  assign icon_instr_ready_o = !fifo_full;
  assign push               = icon_instr_valid_i && icon_instr_ready_o;

  // A held slot whose backend handshake completes this cycle can be reloaded at once.
  assign avail = ~icon_instr_dispatch_valid_o | icon_instr_dispatch_ready_i;

  always_comb begin
    int idx;
    any_avail = 1'b0;
    chosen    = '0;
    idx       = 0;
    for (int k = 0; k < NUM_ICON_CHANNELS; k++) begin
      idx = (int'(rr) + k) % NUM_ICON_CHANNELS;
      if (!any_avail && avail[idx]) begin
        any_avail = 1'b1;
        chosen    = CW'(idx);
      end
    end
  end

  assign rr_next = (chosen == CW'(NUM_ICON_CHANNELS - 1)) ? '0 : chosen + 1'b1;

  assign pop = !fifo_empty && any_avail;

`ifdef ICON_DISP_BYPASS_EN
  assign bypass = push && fifo_empty && any_avail;
`else
  assign bypass = 1'b0;
`endif

  assign alloc      = pop || bypass;
  assign alloc_data = bypass ? icon_instr_i : mem[rd_ptr[AW-1:0]];
  assign fifo_wr    = push && !bypass && !flush_i;

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem[wr_ptr[AW-1:0]] <= icon_instr_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      icon_instr_dispatch_valid_o <= '0;
      icon_instr_dispatch_o       <= '0;
      rr                          <= '0;
    end else if (flush_i) begin
      icon_instr_dispatch_valid_o <= '0;
      rr                          <= '0;
    end else begin
      for (int c = 0; c < NUM_ICON_CHANNELS; c++) begin
        if (alloc && (chosen == CW'(c))) begin
          icon_instr_dispatch_o[c]       <= alloc_data;
          icon_instr_dispatch_valid_o[c] <= 1'b1;
        end else if (icon_instr_dispatch_ready_i[c]) begin
          icon_instr_dispatch_valid_o[c] <= 1'b0;
        end
      end
      if (alloc) begin
        rr <= rr_next;
      end
    end
  end

endmodule

// File: tb/tb_front_icon_dispatcher.sv
// tb/tb_front_icon_dispatcher.sv - directed self-checking bench for front_icon_dispatcher
module tb_front_icon_dispatcher;
  import pkg_dtypes::*;

  logic                  clk = 1'b0;
  logic                  reset_n;
  type_icon_instr        instr;
  logic                  valid_in;
  logic                  ready_out;
  logic                  flush;
  type_icon_instr [3:0]  disp;
  logic [3:0]            disp_valid;
  logic [3:0]            disp_ready;
  logic [3:0]            occ;

  int compared   = 0;
  int mismatched = 0;

  front_icon_dispatcher #(.NUM_ICON_CHANNELS(4), .FIFO_DEPTH(8)) dut (
    .clk                         (clk),
    .reset_n                     (reset_n),
    .icon_instr_i                (instr),
    .icon_instr_valid_i          (valid_in),
    .icon_instr_ready_o          (ready_out),
    .flush_i                     (flush),
    .icon_instr_dispatch_o       (disp),
    .icon_instr_dispatch_valid_o (disp_valid),
    .icon_instr_dispatch_ready_i (disp_ready),
    .occupancy_o                 (occ)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] item(input int k);
    return 32'hC0DE_0000 | 32'(k);
  endfunction

  function automatic logic [3:0] mask(input int n);
    return (n >= 4) ? 4'hF : 4'((1 << n) - 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    instr      = '0;
    valid_in   = 1'b0;
    flush      = 1'b0;
    disp_ready = 4'h0;
    #2;
    chk("rst_valid", 32'(disp_valid), 32'h0);
    chk("rst_occ", 32'(occ), 32'h0);
    chk("rst_ready", 32'(ready_out), 32'h1);
    chk("rst_disp0", 32'(disp[0]), 32'h0);
    step();
    step();
    reset_n = 1'b1;

    // Single instruction with the backend always ready
    disp_ready = 4'hF;
    instr      = item(0);
    valid_in   = 1'b1;
    step();
    valid_in   = 1'b0;
`ifdef ICON_DISP_BYPASS_EN
    chk("t2_e0_valid", 32'(disp_valid), 32'h1);
    chk("t2_e0_occ", 32'(occ), 32'h0);
    chk("t2_e0_data", 32'(disp[0]), item(0));
    step();
    chk("t2_e1_valid", 32'(disp_valid), 32'h0);
`else
    chk("t2_e0_valid", 32'(disp_valid), 32'h0);
    chk("t2_e0_occ", 32'(occ), 32'h1);
    step();
    chk("t2_e1_valid", 32'(disp_valid), 32'h1);
    chk("t2_e1_data", 32'(disp[0]), item(0));
    chk("t2_e1_occ", 32'(occ), 32'h0);
    step();
    chk("t2_e2_valid", 32'(disp_valid), 32'h0);
`endif

    flush = 1'b1;
    step();
    flush = 1'b0;

    // Backend stalled: four slots fill in order, fifth stays in FIFO
    disp_ready = 4'h0;
    for (int k = 0; k < 5; k++) begin
      instr    = item(k);
      valid_in = 1'b1;
      step();
`ifdef ICON_DISP_BYPASS_EN
      chk($sformatf("t3_valid_e%0d", k), 32'(disp_valid), 32'(mask(k + 1)));
`else
      chk($sformatf("t3_valid_e%0d", k), 32'(disp_valid), 32'(mask(k)));
`endif
    end
    valid_in = 1'b0;
    step();
    chk("t3_valid_full", 32'(disp_valid), 32'hF);
    for (int k = 0; k < 20; k++) step();
    chk("t3_valid_hold", 32'(disp_valid), 32'hF);
    chk("t3_occ", 32'(occ), 32'h1);
    for (int c = 0; c < 4; c++) chk($sformatf("t3_disp%0d", c), 32'(disp[c]), item(c));

    // Fill the FIFO to capacity
    for (int k = 5; k < 12; k++) begin
      instr    = item(k);
      valid_in = 1'b1;
      step();
    end
    chk("t4_occ_full", 32'(occ), 32'h8);
    chk("t4_ready_full", 32'(ready_out), 32'h0);
    instr = item(99);
    step();
    valid_in = 1'b0;
    chk("t4_occ_nopush", 32'(occ), 32'h8);
    disp_ready = 4'b0100;
    step();
    disp_ready = 4'h0;
    chk("t4_valid_nogap", 32'(disp_valid), 32'hF);
    chk("t4_disp2_reload", 32'(disp[2]), item(4));
    chk("t4_disp1_stable", 32'(disp[1]), item(1));
    chk("t4_occ7", 32'(occ), 32'h7);
    chk("t4_ready", 32'(ready_out), 32'h1);

    // Flush from a full state with a simultaneous push
    instr    = item(12);
    valid_in = 1'b1;
    step();
    chk("t5_occ_refill", 32'(occ), 32'h8);
    flush    = 1'b1;
    instr    = item(13);
    valid_in = 1'b1;
    step();
    flush    = 1'b0;
    valid_in = 1'b0;
    chk("t5_valid", 32'(disp_valid), 32'h0);
    chk("t5_occ", 32'(occ), 32'h0);
    chk("t5_ready", 32'(ready_out), 32'h1);
    step();
    step();
    step();
    chk("t5_no_dispatch", 32'(disp_valid), 32'h0);
    instr    = item(14);
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    step();
    chk("t5_ch0_valid", 32'(disp_valid), 32'h1);
    chk("t5_ch0_data", 32'(disp[0]), item(14));

    // Latency from an empty FIFO with ch0 free
    flush = 1'b1;
    step();
    flush    = 1'b0;
    instr    = item(15);
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
`ifdef ICON_DISP_BYPASS_EN
    chk("t6_valid_e0", 32'(disp_valid), 32'h1);
    chk("t6_occ_e0", 32'(occ), 32'h0);
`else
    chk("t6_valid_e0", 32'(disp_valid), 32'h0);
    chk("t6_occ_e0", 32'(occ), 32'h1);
`endif
    step();
    chk("t6_valid_e1", 32'(disp_valid), 32'h1);
    chk("t6_data_e1", 32'(disp[0]), item(15));

    // Asynchronous reset with slots held
    instr    = item(16);
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    reset_n  = 1'b0;
    #1;
    chk("t1_valid", 32'(disp_valid), 32'h0);
    chk("t1_occ", 32'(occ), 32'h0);
    chk("t1_ready", 32'(ready_out), 32'h1);
    for (int c = 0; c < 4; c++) chk($sformatf("t1_disp%0d", c), 32'(disp[c]), 32'h0);
    step();
    reset_n  = 1'b1;
    instr    = item(17);
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    step();
    chk("t1_after_valid", 32'(disp_valid), 32'h1);
    chk("t1_after_data", 32'(disp[0]), item(17));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/front_icon_dispatcher.md
Name: front_icon_dispatcher

Overview:
- Front-end initiator for the backend interconnect-instruction dispatch bus.
- Accepts one interconnect (icon) instruction per cycle from rename and buffers it in a FIFO.
- Allocates each instruction round-robin to one of NUM_ICON_CHANNELS per-channel output slots.
- Drives each channel's valid/ready handshake toward the backend icon controller, which sets channel source address and receiver list.

Parameters:
NUM_ICON_CHANNELS, 4, number of icon channels / output slots; must match the backend.
FIFO_DEPTH, 8, entries in the input FIFO; power of 2, minimum 2.

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous, active-low
icon_instr_i  in  type_icon_instr (pkg_dtypes)  instruction from rename
icon_instr_valid_i  in  1  input valid
icon_instr_ready_o  out  1  input ready; equals !fifo_full
flush_i  in  1  synchronous pipeline flush
icon_instr_dispatch_o  out  type_icon_instr [NUM_ICON_CHANNELS-1:0]  per-channel instruction
icon_instr_dispatch_valid_o  out  1 [NUM_ICON_CHANNELS-1:0]  per-channel valid
icon_instr_dispatch_ready_i  in  1 [NUM_ICON_CHANNELS-1:0]  per-channel ready from backend
occupancy_o  out  $clog2(FIFO_DEPTH)+1  FIFO entry count (slots excluded)

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (reset_n). Flush is synchronous.
- Reset values:
  - all dispatch_valid_o = 0; all dispatch_o = 0
  - occupancy_o = 0; icon_instr_ready_o = 1
  - FIFO read/write pointers = 0; round-robin pointer rr = 0
- Push: icon_instr_valid_i && icon_instr_ready_o at a rising edge writes the FIFO.
  - ready_o does not depend on a same-cycle pop.
  - When full, ready_o = 0 even if a pop occurs that cycle.
- Slot state per channel c: FREE (valid 0) or HELD (valid 1).
- Slot c is "available" in a cycle if FREE, or if HELD with dispatch_ready_i[c] = 1 (handshake completes this cycle).
- Pop/allocation, at most one per cycle:
  - Condition: FIFO non-empty and at least one slot available.
  - Choose the first available channel searching upward from rr, modulo NUM_ICON_CHANNELS.
  - At the edge, the FIFO head loads into that slot, the slot becomes HELD, and rr = chosen+1 with wrap (N-1 -> 0).
- Handshake:
  - A HELD slot keeps dispatch_o and dispatch_valid_o stable until dispatch_ready_i[c] = 1 at an edge.
  - At that edge the slot becomes FREE, unless it is reloaded in the same cycle, in which case valid stays 1 and data updates.
  - ready_i while FREE is ignored.
  - Multiple channels may complete handshakes in the same cycle.
- Latency: input accepted at edge E yields earliest dispatch_valid_o after edge E+1 (2 cycles).
- Simultaneous push and pop: occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
  - Full/empty detection uses an extra pointer MSB.
- Empty FIFO: no allocation; rr unchanged.
- Capacity with all ready_i low: FIFO_DEPTH + NUM_ICON_CHANNELS instructions.
- flush_i = 1 at an edge:
  - FIFO emptied; all slots FREE; rr = 0.
  - A push in the same cycle is discarded.
  - A same-cycle handshake still counts as completed for the backend.
  - Flush overrides all other updates.
- Reset mid-operation: immediate return to reset values; in-flight slots are lost.

Optional Feature:
ICON_DISP_BYPASS_EN
- Defined: when the FIFO is empty (and the FIFO is not popped that cycle) and a push occurs with a slot available, the input loads directly into the chosen slot.
  - FIFO is not written and occupancy stays 0.
  - Latency is 1 cycle: valid_o after edge E.
  - rr advances exactly as for a normal pop.
- Undefined: every instruction passes through the FIFO; latency is 2 cycles.

Test Plan:
1. Assert reset_n = 0 mid-traffic with slots HELD -> all valid_o = 0, occupancy_o = 0, ready_o = 1 immediately; after release, the first push goes to ch0.
2. All ready_i = 1; push A at edge 0 -> ch0 valid with A after edge 1 (2 cycles), handshake at edge 2; occupancy peaks at 1.
3. All ready_i = 0; push A,B,C,D,E back-to-back -> ch0..ch3 receive A..D after edges 1..4; E stays in the FIFO (occupancy 1); all slots hold data stable for 20 cycles.
4. All ready_i = 0; push continuously -> 12 instructions accepted (4 slots + 8 FIFO); ready_o = 0 after the 12th; occupancy_o = 8. Then ready_i[2] = 1 for one cycle -> ch2 reloaded with no valid gap, occupancy 7, ready_o = 1.
5. Scenario 4 state, then flush_i = 1 with a simultaneous push -> next cycle all valid = 0, occupancy 0, rr = 0; the pushed instruction is never dispatched; next push goes to ch0.
6. With ICON_DISP_BYPASS_EN defined, empty FIFO, ch0 free, push A at edge 0 -> ch0 valid after edge 0, occupancy stays 0. Without the macro -> valid after edge 1.
